// File: rtl/app_sched_pkg.sv
// Shared types and constants for the app scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package app_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        BLANK = 2'd2
    } sched_state_t;

    localparam logic [15:0] BLACK_565 = 16'h0000;
    localparam int          BTN_W     = 5;

endpackage

// File: rtl/app_scheduler_if.sv
// Bundles the app-side inputs and display/LED/button outputs of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; frame_begin paces the display side.
interface app_scheduler_if #(
    parameter int NUM_APPS = 4
);
    import app_sched_pkg::*;

    logic [NUM_APPS-1:0]       app_req;
    logic                      frame_begin;
    logic [BTN_W-1:0]          btn_in;
    logic [NUM_APPS*16-1:0]    oled_in;
    logic [NUM_APPS*16-1:0]    led_in;
    logic [15:0]               oled_data;
    logic [15:0]               led;
    logic [NUM_APPS*BTN_W-1:0] btn_out;
    logic [2:0]                active_app;
    logic                      switching;

    modport master (
        output app_req, frame_begin, btn_in, oled_in, led_in,
        input  oled_data, led, btn_out, active_app, switching
    );

    modport slave (
        input  app_req, frame_begin, btn_in, oled_in, led_in,
        output oled_data, led, btn_out, active_app, switching
    );

endinterface

// File: rtl/app_req_stabilizer.sv
// Priority-encodes the switch requests and only accepts one that has held steady.
// Latency: accepted follows a request STABLE_CYCLES+1 edges after it is first sampled.
// Backpressure: none; a request that changes before it settles is simply forgotten.
module app_req_stabilizer #(
    parameter int NUM_APPS      = 4,
    parameter int STABLE_CYCLES = 250000
) (
    input  logic                basys_clk,
    input  logic                reset,
    input  logic [NUM_APPS-1:0] app_req,
    output logic [2:0]          accepted
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [2:0]    cand;
    logic [2:0]    last_cand;
    logic [2:0]    acc_q;
    logic [CW-1:0] stab_cnt;

    // Highest set request bit wins; no bits set falls back to app 0.
    always_comb begin
        cand = '0;
        for (int k = 0; k < NUM_APPS; k++) begin
            if (app_req[k]) begin
                cand = 3'(k);
            end
        end
    end

    // Present the settled candidate, otherwise keep the last accepted choice.
    always_comb begin
        accepted = (stab_cnt == CNT_MAX) ? last_cand : acc_q;
    end

    // Restart the hold timer whenever the candidate moves; saturate once settled.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            last_cand <= '0;
            stab_cnt  <= '0;
            acc_q     <= '0;
        end else begin
            acc_q <= accepted;
            if (cand != last_cand) begin
                last_cand <= cand;
                stab_cnt  <= '0;
            end else if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/app_scheduler.sv
// Shares OLED, LEDs and buttons between app cores, switching only on frame boundaries with black frames in between.
// Latency: oled_data/btn_out combinational, led registered (1 cycle); optional APP_SCHED_LED_IND_EN adds an app indicator on led[15:16-NUM_APPS].
// Backpressure: none; a switch waits for frame_begin, and buttons are dropped while switching.
module app_scheduler
    import app_sched_pkg::*;
#(
    parameter int NUM_APPS      = 4,
    parameter int STABLE_CYCLES = 250000,
    parameter int BLANK_FRAMES  = 2
) (
    input  logic            basys_clk,
    input  logic            reset,
    app_scheduler_if.slave  bus
);

    localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES);

    sched_state_t state;
    logic [2:0]   active_app;
    logic [2:0]   target;
    logic [2:0]   accepted;
    logic [3:0]   blank_cnt;
    logic         switching_q;
    logic [15:0]  led_q;
    logic [15:0]  led_nxt;
    logic [15:0]  app_pix;
    logic [15:0]  app_led;
    logic [NUM_APPS*BTN_W-1:0] btn_route;

    app_req_stabilizer #(
        .NUM_APPS      (NUM_APPS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .basys_clk (basys_clk),
        .reset     (reset),
        .app_req   (bus.app_req),
        .accepted  (accepted)
    );

    // Switch sequencer: wait for a frame edge, swap apps, then blank whole frames.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            state       <= RUN;
            active_app  <= '0;
            target      <= '0;
            blank_cnt   <= '0;
            switching_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // A frame_begin in this same cycle is deliberately not used.
                    if (accepted != active_app) begin
                        target      <= accepted;
                        state       <= DRAIN;
                        switching_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.frame_begin) begin
                        state      <= BLANK;
                        blank_cnt  <= '0;
                        active_app <= target;
                    end
                end
                BLANK: begin
                    if (bus.frame_begin) begin
                        blank_cnt <= blank_cnt + 4'd1;
                        if (blank_cnt + 4'd1 == BLANK_LAST) begin
                            state       <= RUN;
                            switching_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= RUN;
                    switching_q <= 1'b0;
                end
            endcase
        end
    end

    // Pick the active app's pixel and LED slices.
    always_comb begin
        app_pix = '0;
        app_led = '0;
        for (int k = 0; k < NUM_APPS; k++) begin
            if (active_app == 3'(k)) begin
                app_pix = bus.oled_in[k*16 +: 16];
                app_led = bus.led_in[k*16 +: 16];
            end
        end
    end

    // Route buttons to the active app only while running; drop them otherwise.
    always_comb begin
        btn_route = '0;
        if (!reset && state == RUN) begin
            for (int k = 0; k < NUM_APPS; k++) begin
                if (active_app == 3'(k)) begin
                    btn_route[k*BTN_W +: BTN_W] = bus.btn_in;
                end
            end
        end
    end

    // Next LED value: follow the app while running, freeze during a switch.
    always_comb begin
        led_nxt = led_q;
        if (state == RUN) begin
            led_nxt = app_led;
        end
`ifdef APP_SCHED_LED_IND_EN
        // Top bits show which app is (or is about to be) on screen.
        for (int k = 0; k < NUM_APPS; k++) begin
            led_nxt[16-NUM_APPS+k] = (((state == RUN) ? active_app : target) == 3'(k));
        end
`endif
    end

    // LED output register.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_nxt;
        end
    end

    assign bus.oled_data  = (state == BLANK) ? BLACK_565 : app_pix;
    assign bus.btn_out    = btn_route;
    assign bus.led        = led_q;
    assign bus.active_app = active_app;
    assign bus.switching  = switching_q;

endmodule

// File: tb/tb_app_scheduler.sv
// Randomized and directed bench for app_scheduler against a frame-level reference model.
// Latency: outputs compared every cycle between clock edges.
// Backpressure: n/a.
module tb_app_scheduler;

    localparam int NA = 4;
    localparam int SC = 20;
    localparam int BF = 2;

    logic basys_clk = 1'b0;
    logic reset;

    app_scheduler_if #(.NUM_APPS(NA)) bus ();

    app_scheduler #(
        .NUM_APPS      (NA),
        .STABLE_CYCLES (SC),
        .BLANK_FRAMES  (BF)
    ) dut (
        .basys_clk (basys_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 basys_clk = ~basys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = showing app, 1 = waiting for frame, 2 = blanking.
    bit          m_valid = 1'b0;
    int          m_mode, m_active, m_target, m_frames, m_last, m_acc;
    longint      edge_no = 0;
    longint      m_since;
    logic [15:0] m_led;

    task automatic model_edge();
        int c;
        int acc_now;
        logic [15:0] nl;
        edge_no++;
        if (reset) begin
            m_mode = 0; m_active = 0; m_target = 0; m_frames = 0;
            m_last = 0; m_acc = 0; m_since = edge_no; m_led = '0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        c = 0;
        for (int k = 0; k < NA; k++) if (bus.app_req[k]) c = k;
        // Held for SC edges since it first appeared -> it is the accepted choice.
        acc_now = ((edge_no - 1) - m_since >= SC) ? m_last : m_acc;
        nl = m_led;
        if (m_mode == 0) nl = bus.led_in[m_active*16 +: 16];
`ifdef APP_SCHED_LED_IND_EN
        for (int k = 0; k < NA; k++) nl[16-NA+k] = (((m_mode == 0) ? m_active : m_target) == k);
`endif
        m_led = nl;
        case (m_mode)
            0: if (acc_now != m_active) begin m_target = acc_now; m_mode = 1; end
            1: if (bus.frame_begin) begin m_mode = 2; m_frames = 0; m_active = m_target; end
            default: if (bus.frame_begin) begin
                m_frames++;
                if (m_frames == BF) m_mode = 0;
            end
        endcase
        if (c != m_last) begin m_last = c; m_since = edge_no; end
        m_acc = acc_now;
    endtask

    task automatic compare_outputs();
        logic [15:0]     exp_pix;
        logic [NA*5-1:0] exp_btn;
        if (!m_valid) return;
        exp_pix = (m_mode == 2) ? 16'h0000 : bus.oled_in[m_active*16 +: 16];
        exp_btn = '0;
        if (!reset && m_mode == 0) exp_btn[m_active*5 +: 5] = bus.btn_in;
        check("oled_data",  bus.oled_data,  exp_pix);
        check("btn_out",    bus.btn_out,    exp_btn);
        check("led",        bus.led,        m_led);
        check("active_app", bus.active_app, m_active);
        check("switching",  bus.switching,  m_mode != 0);
    endtask

    // One clock: compare, let the edge happen, advance model, return at negedge.
    task automatic cycle();
        #1;
        compare_outputs();
        @(posedge basys_clk);
        model_edge();
        @(negedge basys_clk);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < NA; k++) begin
            bus.oled_in[k*16 +: 16] = 16'($urandom_range(1, 65535));
            bus.led_in[k*16 +: 16]  = 16'($urandom);
        end
    endtask

    task automatic frame_pulse();
        bus.frame_begin = 1'b1;
        cycle();
        bus.frame_begin = 1'b0;
    endtask

    task automatic wait_switching(input logic lvl, input int budget, output int n);
        n = 0;
        while (bus.switching !== lvl && n < budget) begin
            cycle();
            n++;
        end
    endtask

    int  n;
    bit  saw;

    initial begin
        reset           = 1'b1;
        bus.app_req     = 4'b0100;
        bus.frame_begin = 1'b0;
        bus.btn_in      = '0;
        randomize_data();
        @(negedge basys_clk);
        repeat (3) cycle();

        // Reset state
        reset       = 1'b0;
        bus.app_req = '0;
        #1;
        check("rst_active", bus.active_app, 0);
        check("rst_led",    bus.led,        0);
        check("rst_btn",    bus.btn_out,    0);
        check("rst_sw",     bus.switching,  0);
        repeat (SC + 4) cycle();

        // Glitch shorter than the hold time must be ignored
        bus.app_req = 4'b1000;
        repeat (SC - 1) cycle();
        bus.app_req = '0;
        saw = 1'b0;
        repeat (2 * SC) begin
            cycle();
            if (bus.switching) saw = 1'b1;
        end
        check("glitch_sw",     saw,            0);
        check("glitch_active", bus.active_app, 0);

        // Switch 0 -> 2
        bus.app_req = 4'b0100;
        cycle();
        wait_switching(1'b1, 3 * SC, n);
        check("drain_lat", n, SC + 1);
        repeat (3) cycle();
        frame_pulse();
        #1;
        check("blank_pix", bus.oled_data, 16'h0000);
        check("blank_sw",  bus.switching, 1);
        bus.btn_in = 5'b10000;
        #1;
        check("blank_btn", bus.btn_out, 0);
        cycle();
        bus.btn_in = '0;
        repeat (4) cycle();
        frame_pulse();
        repeat (4) cycle();
        check("blank_hold", bus.switching, 1);
        frame_pulse();
        #1;
        check("run2_active", bus.active_app, 2);
        check("run2_sw",     bus.switching,  0);
        check("run2_pix",    bus.oled_data,  bus.oled_in[47:32]);
        repeat (3) cycle();

        // Switch to app 1, then button routing
        bus.app_req = 4'b0010;
        cycle();
        wait_switching(1'b1, 3 * SC, n);
        check("drain_lat1", n, SC + 1);
        repeat (BF + 1) begin
            frame_pulse();
            repeat (3) cycle();
        end
        check("run1_active", bus.active_app, 1);
        bus.btn_in = 5'b10000;
        #1;
        check("btnc_app1",  bus.btn_out[9], 1);
        check("btnc_route", bus.btn_out,    20'h00200);
        cycle();
        bus.btn_in = '0;
        #1;
        check("btnc_clear", bus.btn_out[9], 0);
        cycle();
`ifdef APP_SCHED_LED_IND_EN
        check("led_ind", bus.led[15:12], 4'b0010);
`endif

        // Reset during a 1 -> 3 switch, in BLANK
        bus.app_req = 4'b1000;
        cycle();
        wait_switching(1'b1, 3 * SC, n);
        check("drain_lat3", n, SC + 1);
        frame_pulse();
        #1;
        check("mid_blank_pix", bus.oled_data, 16'h0000);
        repeat (2) cycle();
        reset       = 1'b1;
        bus.app_req = '0;
        cycle();
        reset = 1'b0;
        #1;
        check("mid_rst_active", bus.active_app, 0);
        check("mid_rst_sw",     bus.switching,  0);
        check("mid_rst_pix",    bus.oled_data,  bus.oled_in[15:0]);
        saw = 1'b0;
        repeat (4) begin
            frame_pulse();
            repeat (5) begin
                cycle();
                if (bus.switching || bus.oled_data == 16'h0000) saw = 1'b1;
            end
        end
        check("mid_rst_noblank", saw, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.app_req = NA'($urandom);
            bus.frame_begin = ($urandom_range(0, 9) == 0);
            bus.btn_in      = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
            reset           = ($urandom_range(0, 799) == 0);
            randomize_data();
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
